// File: rtl/pgm_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_ram_arbiter
//  Description : 16x8 program RAM shared by bulk clear, matrix scan reads,
//                CPU fetch and the bit-level button editor on a single port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pgm_ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int BIT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_ack,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    input  logic              edit_req,
    input  logic [ADDR_W-1:0] edit_addr,
    input  logic [BIT_W-1:0]  edit_bit,
    input  logic              edit_val,
    output logic              edit_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_CNT_DONE = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] c_SRC_CLR  = 2'd0;
    localparam logic [1:0] c_SRC_DISP = 2'd1;
    localparam logic [1:0] c_SRC_CPU  = 2'd2;
    localparam logic [1:0] c_SRC_EDIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ACK = 2'd1,
        ST_MODIFY = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_src;
    logic [ADDR_W-1:0] r_addr;
    logic [BIT_W-1:0]  r_bit;
    logic              r_val;
    logic [DATA_W-1:0] r_rd_q;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rr_last_edit;
    logic              r_disp_block;

    logic              w_grant_vld;
    logic [1:0]        w_grant_src;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_modified;

    // Arbitration: clear first, then scanner unless it already had its turn
    // while cpu/edit wait, then cpu/edit alternating on ties.
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_src  = c_SRC_CLR;
        w_grant_addr = '0;
        if (clr_req) begin
            w_grant_vld = 1'b1;
            w_grant_src = c_SRC_CLR;
        end else if (disp_req && !(r_disp_block && (cpu_req || edit_req))) begin
            w_grant_vld  = 1'b1;
            w_grant_src  = c_SRC_DISP;
            w_grant_addr = disp_addr;
        end else if (cpu_req && (!edit_req || r_rr_last_edit)) begin
            w_grant_vld  = 1'b1;
            w_grant_src  = c_SRC_CPU;
            w_grant_addr = cpu_addr;
        end else if (edit_req) begin
            w_grant_vld  = 1'b1;
            w_grant_src  = c_SRC_EDIT;
            w_grant_addr = edit_addr;
        end
    end

    always_comb begin
        w_modified        = r_rd_q;
        w_modified[r_bit] = r_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acks are masked while rst is high so an abandoned transaction never
    // reports completion.
    always_comb begin
        w_state_nxt = r_state;
        clr_ack     = 1'b0;
        disp_ack    = 1'b0;
        cpu_ack     = 1'b0;
        edit_ack    = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    case (w_grant_src)
                        c_SRC_CLR:  w_state_nxt = ST_CLEAR;
                        c_SRC_EDIT: w_state_nxt = ST_MODIFY;
                        default:    w_state_nxt = ST_RD_ACK;
                    endcase
                end
            end
            ST_RD_ACK: begin
                disp_ack    = (r_src == c_SRC_DISP) && !rst;
                cpu_ack     = (r_src == c_SRC_CPU) && !rst;
                w_state_nxt = ST_IDLE;
            end
            ST_MODIFY: begin
                edit_ack    = !rst;
                w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (r_cnt == c_CNT_DONE) begin
                    clr_ack     = !rst;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data is loaded at grant so it is already valid during the ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src          <= c_SRC_CLR;
            r_addr         <= '0;
            r_bit          <= '0;
            r_val          <= 1'b0;
            r_rd_q         <= '0;
            r_rd_data      <= '0;
            r_cnt          <= '0;
            r_rr_last_edit <= 1'b1;
            r_disp_block   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_src  <= w_grant_src;
                        r_addr <= w_grant_addr;
                        r_bit  <= edit_bit;
                        r_val  <= edit_val;
                        r_rd_q <= r_mem[w_grant_addr];
                        r_cnt  <= '0;
                        case (w_grant_src)
                            c_SRC_DISP: begin
                                r_rd_data    <= r_mem[w_grant_addr];
                                r_disp_block <= 1'b1;
                            end
                            c_SRC_CPU: begin
                                r_rd_data      <= r_mem[w_grant_addr];
                                r_disp_block   <= 1'b0;
                                r_rr_last_edit <= 1'b0;
                            end
                            c_SRC_EDIT: begin
                                r_disp_block   <= 1'b0;
                                r_rr_last_edit <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; only an in-flight write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_MODIFY) begin
                r_mem[r_addr] <= w_modified;
            end else if (r_state == ST_CLEAR && !r_cnt[ADDR_W]) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= '0;
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pgm_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pgm_ram_arbiter
//  Description : Self-checking bench: word-level RAM model plus directed tests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pgm_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       clr_req,  clr_ack;
    logic       disp_req, disp_ack;
    logic [3:0] disp_addr;
    logic       cpu_req,  cpu_ack;
    logic [3:0] cpu_addr;
    logic       edit_req, edit_ack;
    logic [3:0] edit_addr;
    logic [2:0] edit_bit;
    logic       edit_val;
    logic [7:0] rd_data;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_mem   [16];
    bit         m_known [16];
    logic [7:0] last_rd;

    pgm_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .BIT_W(3)) dut (
        .clk(clk), .rst(rst),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .edit_req(edit_req), .edit_addr(edit_addr), .edit_bit(edit_bit),
        .edit_val(edit_val), .edit_ack(edit_ack),
        .rd_data(rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // Model: one op per ack, reads must return the modelled word, data holds between reads.
    always @(negedge clk) begin
        int n;
        if (rst) begin
            last_rd = 8'h00;
        end else begin
            n = int'(cpu_ack) + int'(disp_ack) + int'(edit_ack) + int'(clr_ack);
            chk("one_ack_per_cycle", n <= 1, 1);
            if (n != 0) chk("busy_during_ack", busy, 1);
            if (cpu_ack) begin
                if (m_known[cpu_addr]) chk("model_cpu_rd", rd_data, m_mem[cpu_addr]);
                last_rd = rd_data;
            end
            if (disp_ack) begin
                if (m_known[disp_addr]) chk("model_disp_rd", rd_data, m_mem[disp_addr]);
                last_rd = rd_data;
            end
            if (!cpu_ack && !disp_ack) chk("rd_data_hold", rd_data, last_rd);
            if (edit_ack) m_mem[edit_addr][edit_bit] = edit_val;
            if (clr_ack) begin
                for (int i = 0; i < 16; i++) begin
                    m_mem[i]   = 8'h00;
                    m_known[i] = 1'b1;
                end
            end
        end
    end

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output int lat);
        bit got = 0;
        cpu_addr = a;
        cpu_req  = 1'b1;
        lat = 0;
        d = 8'h00;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) begin
                d   = rd_data;
                got = 1;
            end
        end
        if (!got) chk("cpu_ack_timeout", 0, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic edit_op(input logic [3:0] a, input logic [2:0] b, input logic v);
        bit got = 0;
        edit_addr = a;
        edit_bit  = b;
        edit_val  = v;
        edit_req  = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (edit_ack) got = 1;
        end
        if (!got) chk("edit_ack_timeout", 0, 1);
        @(posedge clk); #1;
        edit_req = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] v);
        for (int b = 0; b < 8; b++) edit_op(a, 3'(b), v[b]);
    endtask

    task automatic clear_ram();
        bit got = 0;
        clr_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (clr_ack) got = 1;
        end
        if (!got) chk("clr_ack_timeout", 0, 1);
        @(posedge clk); #1;
        clr_req = 1'b0;
    endtask

    // Collect the order of n acks with requests held; acks must never be back to back.
    task automatic collect(input int n, output string s);
        int  k = 0;
        bit  prev = 0;
        bit  cur;
        s = "";
        for (int i = 0; i < 100 && k < n; i++) begin
            @(negedge clk);
            cur = disp_ack | cpu_ack | edit_ack | clr_ack;
            if (cur && prev) chk("ack_single_pulse", 0, 1);
            if (disp_ack) s = {s, "d"};
            if (cpu_ack)  s = {s, "c"};
            if (edit_ack) s = {s, "e"};
            if (cur) k++;
            prev = cur;
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        edit_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         lat;
        int         busy_cnt;
        bit         got_clr, got_cpu, early_cpu;
        string      order;

        for (int i = 0; i < 16; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 1'b0;
        end
        rst = 1'b1;
        clr_req = 0; disp_req = 0; cpu_req = 0; edit_req = 0;
        disp_addr = 0; cpu_addr = 0; edit_addr = 0; edit_bit = 0; edit_val = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_acks", {clr_ack, disp_ack, cpu_ack, edit_ack}, 4'b0000);

        // cpu and edit both held: alternate, cpu first out of reset
        cpu_addr = 4'd1; edit_addr = 4'd2; edit_bit = 3'd3; edit_val = 1'b1;
        cpu_req = 1'b1; edit_req = 1'b1;
        collect(4, order);
        chk_str("rr_order", order, "cece");

        clear_ram();
        for (int i = 0; i < 16; i++) write_word(4'(i), 8'hFF);

        // clear with cpu pending: 17 busy cycles, then cpu reads zero
        cpu_addr = 4'd9;
        cpu_req = 1'b1;
        clr_req = 1'b1;
        busy_cnt = 0; got_clr = 0; got_cpu = 0; early_cpu = 0;
        for (int i = 0; i < 60 && !got_clr; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (cpu_ack) early_cpu = 1;
            if (clr_ack) got_clr = 1;
        end
        chk("clr_ack_seen", got_clr, 1);
        chk("clr_busy_cycles", busy_cnt, 17);
        chk("cpu_not_before_clr", early_cpu, 0);
        @(posedge clk); #1;
        clr_req = 1'b0;
        for (int i = 0; i < 10 && !got_cpu; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got_cpu = 1;
                chk("cpu_after_clr_data", rd_data, 8'h00);
            end
        end
        chk("cpu_after_clr_seen", got_cpu, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_read(4'(i), d, lat);
            chk("cleared_word", d, 8'h00);
        end

        // preload A3 and fetch it: ack one cycle after grant
        write_word(4'd5, 8'hA3);
        cpu_read(4'd5, d, lat);
        chk("fetch_A3", d, 8'hA3);
        chk("fetch_latency", lat, 2);

        // single-bit set then clear
        write_word(4'd3, 8'h00);
        edit_op(4'd3, 3'd2, 1'b1);
        cpu_read(4'd3, d, lat);
        chk("edit_set_bit2", d, 8'h04);
        edit_op(4'd3, 3'd2, 1'b0);
        cpu_read(4'd3, d, lat);
        chk("edit_clr_bit2", d, 8'h00);
        edit_op(4'd6, 3'd7, 1'b1);
        cpu_read(4'd6, d, lat);
        chk("edit_set_bit7", d, 8'h80);

        // three-way contention with scanner re-requesting; last grant was edit
        edit_op(4'd0, 3'd0, 1'b0);
        disp_addr = 4'd5; cpu_addr = 4'd3;
        edit_addr = 4'd4; edit_bit = 3'd1; edit_val = 1'b1;
        disp_req = 1'b1; cpu_req = 1'b1; edit_req = 1'b1;
        collect(4, order);
        chk_str("contention_order", order, "dcde");
        cpu_read(4'd4, d, lat);
        chk("contention_edit_result", d, 8'h02);

        // reset during MODIFY: no ack, no write, outputs back to reset values
        write_word(4'd7, 8'h10);
        edit_addr = 4'd7; edit_bit = 3'd0; edit_val = 1'b1;
        edit_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_modify_no_ack", edit_ack, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        edit_req = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_data", rd_data, 8'h00);
        chk("post_rst_acks", {clr_ack, disp_ack, cpu_ack, edit_ack}, 4'b0000);
        cpu_read(4'd7, d, lat);
        chk("rst_modify_word_kept", d, 8'h10);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
